// File: rtl/bldc_adc_spi.sv
// bldc_adc_spi: SPI front end for an 8-channel, 12-bit serial ADC (ADC128S022 class).
// Accepts one-channel commands. Runs one 16-bit SPI frame per command (mode 3,
// SCLK idles high). Returns the 12-bit result tagged with its channel number.
// The ADC is pipelined by one frame, so each result belongs to the channel that
// was addressed in the previous frame.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_vld_i, cmd_ch_i   command valid / channel (only [2:0] are used)
//   cmd_ready_o           high while idle; a command is taken on vld & ready
//   rsp_vld_o/sop/eop     one-cycle result pulse (sop and eop mirror vld)
//   rsp_ch_o, rsp_data_o  result channel and data, held until the next result
//   spi_cs_n_o, spi_sclk_o, spi_mosi_o, spi_miso_i   ADC serial interface
//
// state       | meaning
// ST_IDLE     | cs_n high, waiting for a command
// ST_CS_SETUP | cs_n low for CLK_DIV cycles before the first SCLK fall
// ST_SHIFT    | 32 SCLK half-periods, low phase first
// ST_CS_HOLD  | cs_n high for CLK_DIV cycles; the result is issued on entry
module bldc_adc_spi #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld_i,
  input  logic [4:0]  cmd_ch_i,
  output logic        cmd_ready_o,
  output logic        rsp_vld_o,
  output logic        rsp_sop_o,
  output logic        rsp_eop_o,
  output logic [4:0]  rsp_ch_o,
  output logic [11:0] rsp_data_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_cnt_nxt;
  logic [4:0]  ph_cnt, ph_cnt_nxt;
  logic [15:0] tx_sr, tx_sr_nxt;
  logic [15:0] rx_sr, rx_sr_nxt;
  logic [2:0]  ch_lat, ch_lat_nxt;
  logic [2:0]  prev_ch, prev_ch_nxt;
  logic        cs_n_nxt, sclk_nxt, mosi_nxt, ready_nxt, rsp_vld_nxt;
  logic [4:0]  rsp_ch_nxt;
  logic [11:0] rsp_data_nxt;
  logic        div_done;

  assign div_done  = (div_cnt == 8'd0);
  assign rsp_sop_o = rsp_vld_o;
  assign rsp_eop_o = rsp_vld_o;

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    ph_cnt_nxt   = ph_cnt;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    ch_lat_nxt   = ch_lat;
    prev_ch_nxt  = prev_ch;
    cs_n_nxt     = spi_cs_n_o;
    sclk_nxt     = spi_sclk_o;
    mosi_nxt     = spi_mosi_o;
    ready_nxt    = 1'b0;
    rsp_vld_nxt  = 1'b0;
    rsp_ch_nxt   = rsp_ch_o;
    rsp_data_nxt = rsp_data_o;
    unique case (state)
      ST_IDLE: begin
        if (cmd_vld_i) begin
          state_nxt   = ST_CS_SETUP;
          div_cnt_nxt = DIV_LOAD;
          ch_lat_nxt  = cmd_ch_i[2:0];
          cs_n_nxt    = 1'b0;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (div_done) begin
          state_nxt   = ST_SHIFT;
          div_cnt_nxt = DIV_LOAD;
          ph_cnt_nxt  = 5'd31;
          sclk_nxt    = 1'b0;
          tx_sr_nxt   = {2'b00, ch_lat, 11'd0};
          mosi_nxt    = 1'b0;
        end else begin
          div_cnt_nxt = div_cnt - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (div_done) begin
          div_cnt_nxt = DIV_LOAD;
          // odd half-periods are the low phases; leaving one is the SCLK rise
          if (ph_cnt[0]) begin
            sclk_nxt   = 1'b1;
            rx_sr_nxt  = {rx_sr[14:0], spi_miso_i};
            ph_cnt_nxt = ph_cnt - 5'd1;
          end else if (ph_cnt == 5'd0) begin
            state_nxt    = ST_CS_HOLD;
            cs_n_nxt     = 1'b1;
            mosi_nxt     = 1'b0;
            rsp_vld_nxt  = 1'b1;
            rsp_data_nxt = rx_sr[11:0];
            rsp_ch_nxt   = {2'b00, prev_ch};
            prev_ch_nxt  = ch_lat;
          end else begin
            sclk_nxt   = 1'b0;
            mosi_nxt   = tx_sr[14];
            tx_sr_nxt  = {tx_sr[14:0], 1'b0};
            ph_cnt_nxt = ph_cnt - 5'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt - 8'd1;
        end
      end
      ST_CS_HOLD: begin
        if (div_done) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      div_cnt     <= 8'd0;
      ph_cnt      <= 5'd0;
      tx_sr       <= 16'd0;
      rx_sr       <= 16'd0;
      ch_lat      <= 3'd0;
      prev_ch     <= 3'd0;
      spi_cs_n_o  <= 1'b1;
      spi_sclk_o  <= 1'b1;
      spi_mosi_o  <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_vld_o   <= 1'b0;
      rsp_ch_o    <= 5'd0;
      rsp_data_o  <= 12'd0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_cnt_nxt;
      ph_cnt      <= ph_cnt_nxt;
      tx_sr       <= tx_sr_nxt;
      rx_sr       <= rx_sr_nxt;
      ch_lat      <= ch_lat_nxt;
      prev_ch     <= prev_ch_nxt;
      spi_cs_n_o  <= cs_n_nxt;
      spi_sclk_o  <= sclk_nxt;
      spi_mosi_o  <= mosi_nxt;
      cmd_ready_o <= ready_nxt;
      rsp_vld_o   <= rsp_vld_nxt;
      rsp_ch_o    <= rsp_ch_nxt;
      rsp_data_o  <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_bldc_adc_spi.sv
// tb_bldc_adc_spi: bench for bldc_adc_spi at CLK_DIV=4 (index 0) and CLK_DIV=1
// (index 1). A behavioural ADC model reacts to cs_n/sclk edges seen on the falling
// clk edge. It shifts out {4'b0, value} and captures DIN. The next conversion channel
// comes from the captured DIN. A frame cut short returns the ADC to channel 0.
module tb_bldc_adc_spi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst4 = 1'b1, rst1 = 1'b1;
  logic        cmd_vld4 = 1'b0, cmd_vld1 = 1'b0;
  logic [4:0]  cmd_ch4 = 5'd0, cmd_ch1 = 5'd0;
  logic        ready4, ready1, rv4, rv1, sop4, sop1, eop4, eop1;
  logic [4:0]  rc4, rc1;
  logic [11:0] rd4, rd1;
  logic        cs4, cs1, sck4, sck1, mosi4, mosi1;
  logic        miso_r [2];
  wire         miso4 = miso_r[0];
  wire         miso1 = miso_r[1];

  bldc_adc_spi #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .cmd_vld_i(cmd_vld4), .cmd_ch_i(cmd_ch4), .cmd_ready_o(ready4),
    .rsp_vld_o(rv4), .rsp_sop_o(sop4), .rsp_eop_o(eop4), .rsp_ch_o(rc4), .rsp_data_o(rd4),
    .spi_cs_n_o(cs4), .spi_sclk_o(sck4), .spi_mosi_o(mosi4), .spi_miso_i(miso4));

  bldc_adc_spi #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .cmd_vld_i(cmd_vld1), .cmd_ch_i(cmd_ch1), .cmd_ready_o(ready1),
    .rsp_vld_o(rv1), .rsp_sop_o(sop1), .rsp_eop_o(eop1), .rsp_ch_o(rc1), .rsp_data_o(rd1),
    .spi_cs_n_o(cs1), .spi_sclk_o(sck1), .spi_mosi_o(mosi1), .spi_miso_i(miso1));

  logic [1:0]       cs_v, sck_v, mosi_v, vld_v, rdy_v, rv_v, sop_v, eop_v;
  logic [1:0][4:0]  ch_v, rc_v;
  logic [1:0][11:0] rd_v;
  assign cs_v   = {cs1, cs4};
  assign sck_v  = {sck1, sck4};
  assign mosi_v = {mosi1, mosi4};
  assign vld_v  = {cmd_vld1, cmd_vld4};
  assign rdy_v  = {ready1, ready4};
  assign rv_v   = {rv1, rv4};
  assign sop_v  = {sop1, sop4};
  assign eop_v  = {eop1, eop4};
  assign ch_v   = {cmd_ch1, cmd_ch4};
  assign rc_v   = {rc1, rc4};
  assign rd_v   = {rd1, rd4};

  logic [11:0] adc_val [8];

  // ADC model and transaction monitor state (written only by the monitor)
  logic        prev_cs [2], prev_sck [2];
  logic [3:0]  bitp [2];
  logic [15:0] word [2], din [2];
  logic [2:0]  conv_ch [2] = '{3'd0, 3'd0};
  int          rises [2], falls [2], tot_falls [2] = '{0, 0}, cs_run [2] = '{0, 0};
  int          nfr_s [2] = '{0, 0}, nfr_e [2] = '{0, 0};
  int          fr_gap [2][64], fr_falls [2][64];
  logic [15:0] fr_din [2][64];
  int          nacc [2] = '{0, 0}, nrsp [2] = '{0, 0}, side_bad [2] = '{0, 0};
  int unsigned acc_t [2][64], rsp_t [2][64];
  logic [2:0]  acc_ch [2][64];
  logic [4:0]  rsp_ch [2][64];
  logic [11:0] rsp_data [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev_cs[i]  <= cs_v[i];
      prev_sck[i] <= sck_v[i];
      cs_run[i]   <= cs_v[i] ? cs_run[i] + 1 : 0;
      if (!cs_v[i] && prev_cs[i]) begin
        bitp[i]            <= 4'd15;
        rises[i]           <= 0;
        falls[i]           <= 0;
        din[i]             <= 16'd0;
        word[i]            <= {4'b0000, adc_val[conv_ch[i]]};
        fr_gap[i][nfr_s[i]] <= cs_run[i];
        nfr_s[i]           <= nfr_s[i] + 1;
      end
      if (prev_sck[i] && !sck_v[i]) begin
        tot_falls[i] <= tot_falls[i] + 1;
        if (!cs_v[i]) begin
          miso_r[i] <= word[i][bitp[i]];
          bitp[i]   <= bitp[i] - 4'd1;
          falls[i]  <= falls[i] + 1;
        end
      end
      if (!prev_sck[i] && sck_v[i] && !prev_cs[i]) begin
        din[i]   <= {din[i][14:0], mosi_v[i]};
        rises[i] <= rises[i] + 1;
      end
      if (cs_v[i] && !prev_cs[i]) begin
        fr_din[i][nfr_e[i]]   <= din[i];
        fr_falls[i][nfr_e[i]] <= falls[i];
        conv_ch[i]            <= (rises[i] == 16) ? din[i][13:11] : 3'd0;
        nfr_e[i]              <= nfr_e[i] + 1;
      end
      if (vld_v[i] && rdy_v[i]) begin
        acc_t[i][nacc[i]]  <= ncyc + 1;
        acc_ch[i][nacc[i]] <= ch_v[i][2:0];
        nacc[i]            <= nacc[i] + 1;
      end
      if (rv_v[i]) begin
        rsp_t[i][nrsp[i]]    <= ncyc;
        rsp_ch[i][nrsp[i]]   <= rc_v[i];
        rsp_data[i][nrsp[i]] <= rd_v[i];
        nrsp[i]              <= nrsp[i] + 1;
      end
      if ((sop_v[i] !== rv_v[i]) || (eop_v[i] !== rv_v[i])) side_bad[i] <= side_bad[i] + 1;
    end
  end

  // bench-side reference state
  int         acc_rd [2] = '{0, 0}, rsp_rd [2] = '{0, 0};
  logic [2:0] model_prev [2] = '{3'd0, 3'd0};
  int         divs [2] = '{4, 1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic v, input logic [4:0] ch);
    if (i == 0) begin cmd_vld4 = v; cmd_ch4 = ch; end
    else begin cmd_vld1 = v; cmd_ch1 = ch; end
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!rdy_v[i] && n < 3000) begin cyc(); n++; end
    if (!rdy_v[i]) chk("ready_timeout", 32'(rdy_v[i]), 32'd1);
  endtask

  task automatic send(input int i, input logic [4:0] ch);
    wait_ready(i);
    set_cmd(i, 1'b1, ch);
    cyc();
    set_cmd(i, 1'b0, 5'($urandom_range(0, 31)));
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while ((nrsp[i] - rsp_rd[i]) < (nacc[i] - acc_rd[i]) && n < 6000) begin cyc(); n++; end
    if ((nrsp[i] - rsp_rd[i]) < (nacc[i] - acc_rd[i]))
      chk("rsp_timeout", 32'(nrsp[i] - rsp_rd[i]), 32'(nacc[i] - acc_rd[i]));
  endtask

  // Each response carries the channel of the command before it and the ADC value for
  // that channel, 33*CLK_DIV cycles after its own command was accepted.
  task automatic check_pending(input int i);
    while (rsp_rd[i] < nrsp[i]) begin
      if (acc_rd[i] >= nacc[i]) begin
        chk("rsp_without_cmd", 32'(nrsp[i]), 32'(rsp_rd[i]));
        rsp_rd[i] = nrsp[i];
      end else begin
        chk("rsp_ch", 32'(rsp_ch[i][rsp_rd[i]]), {29'd0, model_prev[i]});
        chk("rsp_data", 32'(rsp_data[i][rsp_rd[i]]), 32'(adc_val[model_prev[i]]));
        chk("rsp_latency", rsp_t[i][rsp_rd[i]] - acc_t[i][acc_rd[i]], 32'(33 * divs[i]));
        model_prev[i] = acc_ch[i][acc_rd[i]];
        acc_rd[i]++;
        rsp_rd[i]++;
      end
    end
  endtask

  task automatic discard(input int i);
    acc_rd[i]     = nacc[i];
    rsp_rd[i]     = nrsp[i];
    model_prev[i] = 3'd0;
  endtask

  initial begin
    int f0, a0, r0, t0, n;
    logic [2:0] exp_list [7];
    for (int k = 0; k < 8; k++) adc_val[k] = 12'($urandom_range(0, 4095));
    adc_val[0] = 12'hA5C;
    adc_val[3] = 12'h3F1;
    exp_list = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    // reset with random command inputs
    for (int k = 0; k < 3; k++) begin
      set_cmd(0, 1'($urandom), 5'($urandom));
      set_cmd(1, 1'($urandom), 5'($urandom));
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", 32'(cs_v[i]), 32'd1);
      chk("rst_sclk", 32'(sck_v[i]), 32'd1);
      chk("rst_mosi", 32'(mosi_v[i]), 32'd0);
      chk("rst_rsp_vld", 32'(rv_v[i]), 32'd0);
      chk("rst_ready", 32'(rdy_v[i]), 32'd1);
      chk("rst_rsp_data", 32'(rd_v[i]), 32'd0);
      chk("rst_rsp_ch", 32'(rc_v[i]), 32'd0);
    end
    set_cmd(0, 1'b0, 5'd0);
    set_cmd(1, 1'b0, 5'd0);
    rst4 = 1'b0;
    rst1 = 1'b0;
    cyc();
    discard(0);
    discard(1);

    // idle with cmd_vld low: no SPI activity
    f0 = tot_falls[0];
    a0 = nfr_s[0];
    for (int k = 0; k < 200; k++) begin
      set_cmd(0, 1'b0, 5'($urandom));
      cyc();
    end
    chk("idle_sclk_edges", 32'(tot_falls[0] - f0), 32'd0);
    chk("idle_cs_frames", 32'(nfr_s[0] - a0), 32'd0);
    chk("idle_cs_n", 32'(cs_v[0]), 32'd1);

    // first command ch3: returns power-up channel 0
    send(0, 5'd3);
    wait_rsp(0);
    chk("rsp_one_cycle", 32'(rv_v[0]), 32'd0);
    chk("rsp_count1", 32'(nrsp[0] - rsp_rd[0]), 32'd1);
    chk("mosi_p3_5", 32'(fr_din[0][nfr_e[0] - 1][13:11]), 32'b011);
    chk("mosi_frame3", 32'(fr_din[0][nfr_e[0] - 1]), 32'h1800);
    chk("frame_falls", 32'(fr_falls[0][nfr_e[0] - 1]), 32'd16);
    check_pending(0);

    send(0, 5'd5);
    wait_rsp(0);
    chk("mosi_frame5", 32'(fr_din[0][nfr_e[0] - 1]), 32'h2800);
    check_pending(0);

    send(0, 5'($urandom_range(0, 31)));
    wait_rsp(0);
    chk("third_rsp_ch", 32'(rsp_ch[0][rsp_rd[0]]), 32'd5);
    check_pending(0);

    // streaming with cmd_vld held high
    send(0, 5'd0);
    wait_rsp(0);
    check_pending(0);
    wait_ready(0);
    a0 = nacc[0];
    r0 = nrsp[0];
    f0 = nfr_s[0];
    for (int k = 0; k < 7; k++) begin
      set_cmd(0, 1'b1, 5'(k % 6));
      n = 0;
      while (nacc[0] <= a0 + k && n < 400) begin cyc(); n++; end
      if (nacc[0] <= a0 + k) chk("stream_accept_timeout", 32'(nacc[0]), 32'(a0 + k + 1));
    end
    set_cmd(0, 1'b0, 5'd0);
    wait_rsp(0);
    for (int k = 1; k < 7; k++) begin
      chk("stream_period", acc_t[0][a0 + k] - acc_t[0][a0 + k - 1], 32'd137);
      chk("stream_cs_gap", 32'(fr_gap[0][f0 + k] >= 4), 32'd1);
    end
    for (int k = 0; k < 7; k++) begin
      chk("stream_falls", 32'(fr_falls[0][f0 + k]), 32'd16);
      chk("stream_rsp_ch", 32'(rsp_ch[0][r0 + k]), {29'd0, exp_list[k]});
    end
    check_pending(0);

    // reset during SCLK period 9
    send(0, 5'd6);
    t0 = tot_falls[0];
    n = 0;
    while (tot_falls[0] < t0 + 9 && n < 400) begin cyc(); n++; end
    chk("reached_period9", 32'(tot_falls[0] - t0), 32'd9);
    rst4 = 1'b1;
    cyc();
    chk("midrst_cs_n", 32'(cs_v[0]), 32'd1);
    chk("midrst_sclk", 32'(sck_v[0]), 32'd1);
    chk("midrst_mosi", 32'(mosi_v[0]), 32'd0);
    chk("midrst_ready", 32'(rdy_v[0]), 32'd1);
    rst4 = 1'b0;
    r0 = nrsp[0];
    for (int k = 0; k < 200; k++) cyc();
    chk("midrst_no_rsp", 32'(nrsp[0] - r0), 32'd0);
    discard(0);
    send(0, 5'd2);
    wait_rsp(0);
    chk("after_rst_ch", 32'(rsp_ch[0][rsp_rd[0]]), 32'd0);
    check_pending(0);

    // channel wrap: 13 addresses channel 5
    send(0, 5'd13);
    wait_rsp(0);
    chk("wrap_mosi_addr", 32'(fr_din[0][nfr_e[0] - 1][13:11]), 32'b101);
    check_pending(0);
    send(0, 5'($urandom_range(0, 31)));
    wait_rsp(0);
    chk("wrap_rsp_ch", 32'(rsp_ch[0][rsp_rd[0]]), 32'd5);
    check_pending(0);

    // CLK_DIV=1 regression, streaming random channels
    wait_ready(1);
    a0 = nacc[1];
    for (int k = 0; k < 5; k++) begin
      set_cmd(1, 1'b1, 5'($urandom_range(0, 31)));
      n = 0;
      while (nacc[1] <= a0 + k && n < 100) begin cyc(); n++; end
      if (nacc[1] <= a0 + k) chk("div1_accept_timeout", 32'(nacc[1]), 32'(a0 + k + 1));
    end
    set_cmd(1, 1'b0, 5'd0);
    wait_rsp(1);
    for (int k = 1; k < 5; k++)
      chk("div1_period", acc_t[1][a0 + k] - acc_t[1][a0 + k - 1], 32'd35);
    check_pending(1);

    chk("sop_eop_track_vld0", 32'(side_bad[0]), 32'd0);
    chk("sop_eop_track_vld1", 32'(side_bad[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bldc_adc_spi.md
Name: bldc_adc_spi

Overview:
- ADC front end that sits directly upstream of the 6-channel BLDC ADC read controller.
- Accepts one-channel conversion commands on the controller's cmd handshake and runs one 16-bit SPI frame per command to an external 8-channel, 12-bit serial ADC (ADC128S022-class).
- Returns the 12-bit result on the rsp interface, tagged with the channel number.
- The ADC is pipelined by one frame: each frame converts the channel that was addressed in the previous frame.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_vld_i  input  1  command valid
cmd_ch_i  input  5  requested channel; only [2:0] are used
cmd_ready_o  output  1  block can accept a command (IDLE state)
rsp_vld_o  output  1  result valid, one-cycle pulse
rsp_sop_o  output  1  start of packet; equals rsp_vld_o
rsp_eop_o  output  1  end of packet; equals rsp_vld_o
rsp_ch_o  output  5  channel of the result; {2'b00, ch[2:0]}
rsp_data_o  output  12  conversion result
spi_cs_n_o  output  1  ADC chip select, active-low
spi_sclk_o  output  1  SPI clock; idles high (CPOL=1)
spi_mosi_o  output  1  ADC DIN
spi_miso_i  input  1  ADC DOUT

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - cmd_ready_o=1; rsp_vld_o/sop/eop=0; rsp_ch_o=0; rsp_data_o=0.
  - spi_cs_n_o=1; spi_sclk_o=1; spi_mosi_o=0.
  - Internal prev_ch=0, because the ADC converts ch0 first after power-up.
- Handshake: a command is accepted on a clk edge where cmd_vld_i & cmd_ready_o. cmd_ready_o is 1 only in IDLE. The cmd_ch_i[2:0] value is latched on acceptance.
- State machine: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
  - IDLE: cs_n=1, sclk=1. Moves to CS_SETUP on acceptance.
  - CS_SETUP: cs_n=0 for CLK_DIV cycles, sclk=1.
  - SHIFT: 16 SCLK periods of 2*CLK_DIV cycles each.
    - Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - sclk falls on SHIFT entry; the last period ends high.
  - CS_HOLD: cs_n=1 for CLK_DIV cycles, then IDLE.
- MOSI: frame bits 15..0 are {2'b00, ch[2:0], 11'b0}, MSB first. Each bit updates on the SCLK falling edge. spi_mosi_o returns to 0 outside SHIFT.
- MISO: sampled on each SCLK rising edge, i.e. the last clk cycle of each low phase, into a 16-bit shift register (MSB first). Result = sampled bits [11:0]; the 4 leading bits are ignored.
- Response: in the first CS_HOLD cycle, rsp_vld_o/sop/eop pulse high for exactly 1 cycle, with:
  - rsp_data_o = sampled result;
  - rsp_ch_o = {2'b00, prev_ch}.
  - In the same cycle, prev_ch <= latched channel.
  - rsp_data_o and rsp_ch_o hold their values until the next response.
- Latency: accept at edge T gives rsp_vld_o high in cycle T+1+33*CLK_DIV.
- Frame throughput: cmd_ready_o is high again 34*CLK_DIV cycles after acceptance. With cmd_vld_i held high, one command is accepted every 34*CLK_DIV+1 cycles (137 cycles at CLK_DIV=4).
- Channel wrap: cmd_ch_i values 8..31 use [2:0]; for example 13 addresses channel 5.
- cmd_vld_i low while in IDLE: no SPI activity; cs_n stays high.
- Reset mid-frame: rst has priority in every state.
  - All outputs return to reset values on the next edge.
  - prev_ch=0 and no rsp pulse is generated.
  - A partial frame is abandoned; cs_n rising resets the ADC's own frame.
- cmd_vld_i / cmd_ch_i changes outside IDLE are ignored.

Test Plan:
- Hold rst=1 for 3 cycles with random inputs -> cs_n=1, sclk=1, mosi=0, rsp_vld=0, cmd_ready=1, rsp_data=0. Then hold cmd_vld=0 for 200 cycles -> no SCLK edges.
- ADC model returns 0xA5C for ch0 and 0x3F1 for ch3; CLK_DIV=4. Accept cmd_ch=3 at T:
  - mosi is 0,1,1 on SCLK periods 3..5;
  - rsp_vld pulses only in cycle T+133;
  - rsp_ch=0, rsp_data=0xA5C.
- Second command cmd_ch=5 -> rsp_ch=3, rsp_data=0x3F1. Third command -> rsp_ch=5.
- cmd_vld held high with channels 0..5 cycling:
  - acceptances are exactly 137 cycles apart;
  - cs_n high for ≥4 cycles between frames;
  - 16 SCLK falling edges per frame;
  - responses carry channels 0,0,1,2,3,4,5.
- Assert rst during SCLK period 9 -> next cycle cs_n=1, sclk=1, no rsp pulse. The next command returns rsp_ch=0.
- cmd_ch=13 -> MOSI address 101. The following frame's rsp_ch=5. CLK_DIV=1 regression: frame period 35 cycles, data correct.
